// File: rtl/usb_flash_seq_pkg.sv
// Shared types and constants for the DFU page sequencer: state encoding,
// command opcodes and DFU bStatus codes.
package usb_flash_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR_FILL = 2'd2,
    ST_WR_WAIT = 2'd3
  } seq_state_e;

  localparam logic [1:0] OP_DNLOAD = 2'd0;
  localparam logic [1:0] OP_UPLOAD = 2'd1;

  localparam logic [7:0] DFU_OK               = 8'h00;
  localparam logic [7:0] DFU_ERR_CHECK_ERASED = 8'h05;
  localparam logic [7:0] DFU_ERR_PROG         = 8'h06;
  localparam logic [7:0] DFU_ERR_ADDRESS      = 8'h08;
  localparam logic [7:0] DFU_ERR_UNKNOWN      = 8'h0E;

endpackage

// File: rtl/falling_edge_detector.sv
// Registers a level and flags the cycle in which it goes from high to low.
module falling_edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic fall
);

  logic sig_q;
  logic sig_d;

  always_comb sig_d = sig;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_d;
  end

  assign fall = sig_q & ~sig;

endmodule

// File: rtl/usb_flash_page_sequencer.sv
// Maps DFU block commands onto single-page SPI flash bridge transfers.
// Optional FLASH_SEQ_ORDER_CHECK_EN enforces sequential DNLOAD block order.
module usb_flash_page_sequencer
  import usb_flash_seq_pkg::*;
#(
  parameter logic [15:0] BASE_PAGE    = 16'h0200,
  parameter logic [15:0] PAGE_LIMIT   = 16'h0400,
  parameter int          PAGE_SIZE    = 256,
  parameter int          BUSY_TIMEOUT = 2**24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_block,
  input  logic [8:0]  cmd_len,
  input  logic        abort,
  output logic        done,
  output logic [7:0]  status,
  output logic [15:0] flash_address,
  output logic        flash_rd_request,
  output logic        flash_wr_request,
  input  logic        flash_wr_busy,
  input  logic        flash_rd_put,
  input  logic        flash_wr_get,
  output seq_state_e  dbg_state
);

  localparam int             TW          = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [8:0]     PAGE_SIZE_C = 9'(PAGE_SIZE);
  localparam logic [TW-1:0]  TIMEOUT_C   = TW'(BUSY_TIMEOUT);

  seq_state_e    state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [8:0]    len_q, len_d;
  logic [15:0]   addr_q, addr_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic          done_q, done_d;
  logic [7:0]    status_q, status_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seen_busy_q, seen_busy_d;
  logic          aborted_q, aborted_d;
`ifdef FLASH_SEQ_ORDER_CHECK_EN
  logic [15:0]   exp_blk_q, exp_blk_d;
  logic [15:0]   block_q, block_d;
`endif

  logic [16:0]   page;
  logic          addr_bad;
  logic [8:0]    cnt_inc;
  logic [TW-1:0] tmo_inc;
  logic          busy_fall;

  falling_edge_detector u_busy_fall (
    .clk   (clk),
    .reset (reset),
    .sig   (flash_wr_busy),
    .fall  (busy_fall)
  );

  assign page     = {1'b0, BASE_PAGE} + {1'b0, cmd_block};
  assign addr_bad = page[16] || (page[15:0] >= PAGE_LIMIT);
  // Byte counter saturates instead of wrapping.
  assign cnt_inc  = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
  assign tmo_inc  = (tmo_q == TIMEOUT_C) ? tmo_q : tmo_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    done_d      = 1'b0;
    status_d    = status_q;
    tmo_d       = tmo_q;
    seen_busy_d = seen_busy_q;
    aborted_d   = aborted_q;
`ifdef FLASH_SEQ_ORDER_CHECK_EN
    exp_blk_d   = exp_blk_q;
    block_d     = block_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef FLASH_SEQ_ORDER_CHECK_EN
        if (abort) exp_blk_d = 16'd0;
`endif
        if (cmd_valid) begin
          cnt_d = 9'd0;
          len_d = cmd_len;
`ifdef FLASH_SEQ_ORDER_CHECK_EN
          block_d = cmd_block;
`endif
          if (cmd_op[1]) begin
            done_d   = 1'b1;
            status_d = DFU_ERR_UNKNOWN;
          end else if (addr_bad) begin
            done_d   = 1'b1;
            status_d = DFU_ERR_ADDRESS;
          end else if (cmd_len > PAGE_SIZE_C) begin
            done_d   = 1'b1;
            status_d = DFU_ERR_UNKNOWN;
          end else if (cmd_op == OP_UPLOAD) begin
            addr_d   = page[15:0];
            rd_req_d = 1'b1;
            state_d  = ST_RD;
          end else if (cmd_len == 9'd0) begin
            done_d   = 1'b1;
            status_d = DFU_OK;
`ifdef FLASH_SEQ_ORDER_CHECK_EN
            exp_blk_d = 16'd0;
          end else if (cmd_block != exp_blk_q) begin
            done_d   = 1'b1;
            status_d = DFU_ERR_CHECK_ERASED;
`endif
          end else begin
            addr_d    = page[15:0];
            wr_req_d  = 1'b1;
            aborted_d = 1'b0;
            state_d   = ST_WR_FILL;
          end
        end
      end
      ST_RD: begin
        if (abort) begin
          rd_req_d = 1'b0;
          done_d   = 1'b1;
          status_d = DFU_ERR_UNKNOWN;
          state_d  = ST_IDLE;
        end else if (flash_rd_put) begin
          cnt_d = cnt_inc;
          if (cnt_inc == PAGE_SIZE_C) begin
            rd_req_d = 1'b0;
            done_d   = 1'b1;
            status_d = DFU_OK;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_WR_FILL: begin
        // An abort still programs the bytes already handed to the bridge.
        if (abort || (flash_wr_get && (cnt_inc == len_q))) begin
          if (!abort) cnt_d = cnt_inc;
          aborted_d   = abort;
          wr_req_d    = 1'b0;
          seen_busy_d = 1'b0;
          tmo_d       = '0;
          state_d     = ST_WR_WAIT;
        end else if (flash_wr_get) begin
          cnt_d = cnt_inc;
        end
      end
      ST_WR_WAIT: begin
        tmo_d       = tmo_inc;
        seen_busy_d = seen_busy_q | flash_wr_busy;
        if (seen_busy_q && busy_fall) begin
          done_d   = 1'b1;
          status_d = aborted_q ? DFU_ERR_UNKNOWN : DFU_OK;
          state_d  = ST_IDLE;
`ifdef FLASH_SEQ_ORDER_CHECK_EN
          if (!aborted_q) exp_blk_d = block_q + 16'd1;
`endif
        end else if (tmo_inc == TIMEOUT_C) begin
          done_d   = 1'b1;
          status_d = DFU_ERR_PROG;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 9'd0;
      len_q       <= 9'd0;
      addr_q      <= 16'd0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 8'd0;
      tmo_q       <= '0;
      seen_busy_q <= 1'b0;
      aborted_q   <= 1'b0;
`ifdef FLASH_SEQ_ORDER_CHECK_EN
      exp_blk_q   <= 16'd0;
      block_q     <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      done_q      <= done_d;
      status_q    <= status_d;
      tmo_q       <= tmo_d;
      seen_busy_q <= seen_busy_d;
      aborted_q   <= aborted_d;
`ifdef FLASH_SEQ_ORDER_CHECK_EN
      exp_blk_q   <= exp_blk_d;
      block_q     <= block_d;
`endif
    end
  end

  assign cmd_ready        = (state_q == ST_IDLE);
  assign done             = done_q;
  assign status           = status_q;
  assign flash_address    = addr_q;
  assign flash_rd_request = rd_req_q;
  assign flash_wr_request = wr_req_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_usb_flash_page_sequencer.sv
// Scoreboard bench for usb_flash_page_sequencer with a simple bridge model.
// Order-check vectors run only when FLASH_SEQ_ORDER_CHECK_EN is defined.
module tb_usb_flash_page_sequencer;
  import usb_flash_seq_pkg::*;

  localparam int TMO = 1200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_block = 16'd0;
  logic [8:0]  cmd_len = 9'd0;
  logic        abort = 1'b0;
  logic        done;
  logic [7:0]  status;
  logic [15:0] flash_address;
  logic        flash_rd_request;
  logic        flash_wr_request;
  logic        flash_wr_busy = 1'b0;
  logic        flash_rd_put = 1'b0;
  logic        flash_wr_get = 1'b0;
  seq_state_e  dbg_state;

  usb_flash_page_sequencer #(.BUSY_TIMEOUT(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_block        (cmd_block),
    .cmd_len          (cmd_len),
    .abort            (abort),
    .done             (done),
    .status           (status),
    .flash_address    (flash_address),
    .flash_rd_request (flash_rd_request),
    .flash_wr_request (flash_wr_request),
    .flash_wr_busy    (flash_wr_busy),
    .flash_rd_put     (flash_rd_put),
    .flash_wr_get     (flash_wr_get),
    .dbg_state        (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // {status, address seen, beats, address stable}
  logic [33:0] exp_q[$];
  logic        gap_en = 1'b1;
  logic        hold_beats = 1'b0;

  logic [15:0] mon_addr = 16'hFFFF;
  logic [8:0]  mon_beats = 9'd0;
  logic        mon_stable = 1'b1;
  logic [33:0] mon_exp;

  function automatic logic [33:0] mk(input logic [7:0] st, input logic [15:0] a,
                                     input logic [8:0] b);
    return {st, a, b, 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bridge model: beats only while the matching request is high.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      flash_rd_put = flash_rd_request && !hold_beats && !(gap_en && ($urandom_range(0, 3) == 0));
      flash_wr_get = flash_wr_request && !hold_beats && !(gap_en && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor: tracks each transfer and pops the scoreboard on done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_addr = 16'hFFFF; mon_beats = 9'd0; mon_stable = 1'b1;
      end else begin
        if (flash_rd_request || flash_wr_request) begin
          if (mon_addr == 16'hFFFF) mon_addr = flash_address;
          else if (flash_address != mon_addr) mon_stable = 1'b0;
          if ((flash_rd_put && flash_rd_request) || (flash_wr_get && flash_wr_request))
            mon_beats = mon_beats + 9'd1;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            mon_exp = exp_q.pop_front();
            check("completion{status,addr,beats,stable}",
                  {30'd0, status, mon_addr, mon_beats, mon_stable}, {30'd0, mon_exp});
          end
          mon_addr = 16'hFFFF; mon_beats = 9'd0; mon_stable = 1'b1;
        end
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic [1:0] op, input logic [15:0] blk, input logic [8:0] len);
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_block = blk; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_done_seen"}, done, 1);
    check({name, "_ready_with_done"}, cmd_ready, 1);
  endtask

  task automatic wait_wr_fall(input string name);
    int n = 0;
    while (flash_wr_request && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_wr_req_fell"}, flash_wr_request, 0);
  endtask

  task automatic do_upload(input logic [15:0] blk, input logic [15:0] addr);
    exp_q.push_back(mk(DFU_OK, addr, 9'd256));
    issue(OP_UPLOAD, blk, 9'd0);
    check("upload_rd_req_rise", flash_rd_request, 1);
    wait_done("upload");
  endtask

  task automatic do_write(input logic [15:0] blk, input logic [15:0] addr,
                          input logic [8:0] len, input int busy_len);
    logic early;
    exp_q.push_back(mk(DFU_OK, addr, len));
    issue(OP_DNLOAD, blk, len);
    check("write_wr_req_rise", flash_wr_request, 1);
    wait_wr_fall("write");
    flash_wr_busy = 1'b1;
    early = 1'b0;
    repeat (busy_len) begin
      @(posedge clk); #1;
      if (done) early = 1'b1;
    end
    check("write_no_done_while_busy", early, 0);
    flash_wr_busy = 1'b0;
    @(posedge clk); #1;
    check("write_done_after_busy_fall", done, 1);
  endtask

  task automatic do_immediate(input string name, input logic [1:0] op, input logic [15:0] blk,
                              input logic [8:0] len, input logic [7:0] st);
    exp_q.push_back(mk(st, 16'hFFFF, 9'd0));
    issue(op, blk, len);
    check({name, "_done_next_cycle"}, done, 1);
    check({name, "_no_request"}, {flash_rd_request, flash_wr_request}, 0);
    check({name, "_still_idle"}, cmd_ready, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_done", done, 0);
    check("reset_rd_req", flash_rd_request, 0);
    check("reset_wr_req", flash_wr_request, 0);
    check("reset_address", flash_address, 0);
    check("reset_status", status, 0);
    check("reset_state", dbg_state, ST_IDLE);

    // Uploads, including the last page inside the partition
    do_upload(16'h0003, 16'h0203);
    do_upload(16'h01FF, 16'h03FF);

    // Sequential downloads with a long program phase
    do_write(16'h0000, 16'h0200, 9'd256, 1000);
    do_write(16'h0001, 16'h0201, 9'd256, 1000);

    // Immediate completions
    do_immediate("addr_limit", OP_DNLOAD, 16'h0200, 9'd256, DFU_ERR_ADDRESS);
    do_immediate("addr_carry", OP_UPLOAD, 16'hFE00, 9'd0, DFU_ERR_ADDRESS);
    do_immediate("reserved_op2", 2'd2, 16'h0000, 9'd16, DFU_ERR_UNKNOWN);
    do_immediate("reserved_op3", 2'd3, 16'h0000, 9'd16, DFU_ERR_UNKNOWN);
    do_immediate("len_too_big", OP_DNLOAD, 16'h0002, 9'd257, DFU_ERR_UNKNOWN);
    do_immediate("dnload_end", OP_DNLOAD, 16'h0002, 9'd0, DFU_OK);

    // Abort during RD after 10 beats
    gap_en = 1'b0;
    exp_q.push_back(mk(DFU_ERR_UNKNOWN, 16'h0205, 9'd10));
    issue(OP_UPLOAD, 16'h0005, 9'd0);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1; hold_beats = 1'b1;
    @(posedge clk); #1;
    check("rd_abort_req_drop", flash_rd_request, 0);
    check("rd_abort_done", done, 1);
    abort = 1'b0; hold_beats = 1'b0;

    // Abort during WR_FILL after 40 of 100 gets; the partial page still programs
    exp_q.push_back(mk(DFU_ERR_UNKNOWN, 16'h0200, 9'd40));
    issue(OP_DNLOAD, 16'h0000, 9'd100);
    repeat (40) @(posedge clk);
    #1 abort = 1'b1; hold_beats = 1'b1;
    @(posedge clk); #1;
    check("wr_abort_req_drop", flash_wr_request, 0);
    check("wr_abort_waits", done, 0);
    abort = 1'b0; hold_beats = 1'b0;
    flash_wr_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1 flash_wr_busy = 1'b0;
    @(posedge clk); #1;
    check("wr_abort_done_after_busy", done, 1);
    gap_en = 1'b1;

    // Busy stuck high: errPROG after exactly TMO cycles in WR_WAIT
    exp_q.push_back(mk(DFU_ERR_PROG, 16'h0200, 9'd16));
    issue(OP_DNLOAD, 16'h0000, 9'd16);
    wait_wr_fall("timeout");
    flash_wr_busy = 1'b1;
    n = 0;
    while (!done && n < TMO + 50) begin
      @(posedge clk); #1; n++;
    end
    check("timeout_cycles", n, TMO);
    flash_wr_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef FLASH_SEQ_ORDER_CHECK_EN
    do_write(16'h0000, 16'h0200, 9'd8, 5);
    do_immediate("order_skip", OP_DNLOAD, 16'h0002, 9'd8, DFU_ERR_CHECK_ERASED);
    do_immediate("order_reset", OP_DNLOAD, 16'h0002, 9'd0, DFU_OK);
    do_write(16'h0000, 16'h0200, 9'd8, 5);
`endif

    // Reset in the middle of an upload drops the request on the same edge
    gap_en = 1'b0;
    issue(OP_UPLOAD, 16'h0007, 9'd0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_rd_req", flash_rd_request, 0);
    check("midreset_ready", cmd_ready, 1);
    check("midreset_status", status, 0);
    reset = 1'b0;
    gap_en = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
